// File: rtl/regfile_ctrl.sv
// Register-file front-end controller: post-reset clear sweep, core writeback
// pass-through, and one-register-per-request debug access over a req/ack handshake.
module regfile_ctrl #(
    parameter int                ADDR_W   = 5,
    parameter int                DATA_W   = 32,
    parameter int                NUM_REGS = 32,
    parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_waddr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [ADDR_W-1:0] core_a2,
    output logic              core_stall,
    output logic              init_done,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic              rf_we3,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [DATA_W-1:0] rf_wd3,
    output logic [ADDR_W-1:0] rf_a2
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_DBG  = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_dbg_we_q;
    logic [ADDR_W-1:0]   r_dbg_addr_q;
    logic [DATA_W-1:0]   r_dbg_wdata_q;
    logic [DATA_W-1:0]   r_dbg_rdata;
    logic                r_init_done;
    logic                r_dbg_ack;
    logic                w_dbg_wr;

    // x0 is hardwired in the register file, so a debug write to it is dropped here.
    assign w_dbg_wr = r_dbg_we_q && (r_dbg_addr_q != ZERO_ADDR);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_INIT: begin
                if (r_cnt == LAST_ADDR) w_next_state = ST_IDLE;
                else                    w_next_state = ST_INIT;
            end
            ST_IDLE: begin
                if (dbg_req) w_next_state = ST_DBG;
                else         w_next_state = ST_IDLE;
            end
            ST_DBG: w_next_state = ST_ACK;
            ST_ACK: begin
                if (dbg_req) w_next_state = ST_ACK;
                else         w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_INIT;
        endcase
    end

    // Port steering: core owns the ports except during the sweep and the debug cycle
    always_comb begin
        core_stall = 1'b0;
        rf_we3     = core_we;
        rf_a3      = core_waddr;
        rf_wd3     = core_wdata;
        rf_a2      = core_a2;
        case (r_state)
            ST_INIT: begin
                core_stall = 1'b1;
                rf_we3     = 1'b1;
                rf_a3      = r_cnt;
                rf_wd3     = INIT_VAL;
            end
            ST_DBG: begin
                core_stall = 1'b1;
                rf_we3     = w_dbg_wr;
                rf_a3      = r_dbg_addr_q;
                rf_wd3     = r_dbg_wdata_q;
                rf_a2      = r_dbg_addr_q;
            end
            default: begin
                core_stall = 1'b0;
            end
        endcase
    end

    // Sweep counter, debug request capture and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt         <= ONE_ADDR;
            r_init_done   <= 1'b0;
            r_dbg_ack     <= 1'b0;
            r_dbg_rdata   <= {DATA_W{1'b0}};
            r_dbg_we_q    <= 1'b0;
            r_dbg_addr_q  <= ZERO_ADDR;
            r_dbg_wdata_q <= {DATA_W{1'b0}};
        end else begin
            if (r_state == ST_INIT) r_cnt <= r_cnt + ONE_ADDR;
            else                    r_cnt <= r_cnt;

            if ((r_state == ST_INIT) && (r_cnt == LAST_ADDR)) r_init_done <= 1'b1;
            else                                              r_init_done <= r_init_done;

            r_dbg_ack <= (w_next_state == ST_ACK);

            if ((r_state == ST_IDLE) && dbg_req) begin
                r_dbg_we_q    <= dbg_we;
                r_dbg_addr_q  <= dbg_addr;
                r_dbg_wdata_q <= dbg_wdata;
            end else begin
                r_dbg_we_q    <= r_dbg_we_q;
                r_dbg_addr_q  <= r_dbg_addr_q;
                r_dbg_wdata_q <= r_dbg_wdata_q;
            end

            // Read and write share this edge, so a debug write captures the old value.
            if (r_state == ST_DBG) r_dbg_rdata <= rf_rd2;
            else                   r_dbg_rdata <= r_dbg_rdata;
        end
    end

    assign init_done = r_init_done;
    assign dbg_ack   = r_dbg_ack;
    assign dbg_rdata = r_dbg_rdata;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: behavioural register file plus a reference model of the
// controller; directed vector table, hand-written corner sequences and random traffic.
module tb_regfile_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;

    typedef struct packed {
        logic          rst_n;
        logic          core_we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [AW-1:0] a2;
        logic          req;
        logic          dwe;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dwdata;
    } in_t;

    typedef struct packed {
        logic          stall;
        logic          we3;
        logic [AW-1:0] a3;
        logic [DW-1:0] wd3;
        logic [AW-1:0] a2;
        logic          ack;
        logic [DW-1:0] rdata;
        logic          done;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          core_we = 1'b0;
    logic [AW-1:0] core_waddr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic [AW-1:0] core_a2 = '0;
    logic          dbg_req = 1'b0;
    logic          dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          core_stall, init_done, dbg_ack, rf_we3;
    logic [DW-1:0] dbg_rdata, rf_wd3, rf_rd2;
    logic [AW-1:0] rf_a3, rf_a2;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .INIT_VAL(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_we(core_we), .core_waddr(core_waddr), .core_wdata(core_wdata), .core_a2(core_a2),
        .core_stall(core_stall), .init_done(init_done),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .rf_rd2(rf_rd2), .rf_we3(rf_we3), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_a2(rf_a2)
    );

    always #5 clk = ~clk;

    // Behavioural 32x32 register file; filled with junk during reset so the sweep is visible.
    logic [DW-1:0] rf_mem [NR];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NR; k++) rf_mem[k] <= 32'hBAD0_0000 + 32'(k);
        end else if (rf_we3 && (rf_a3 != 5'd0)) begin
            rf_mem[rf_a3] <= rf_wd3;
        end
    end
    assign rf_rd2 = (rf_a2 == 5'd0) ? 32'h0000_0000 : rf_mem[rf_a2];

    // Reference model
    bit            m_valid = 1'b0;
    int            m_sweep;
    bit            m_dbg_cycle;
    bit            m_acking;
    bit            m_lat_we;
    logic [AW-1:0] m_lat_addr;
    logic [DW-1:0] m_lat_wdata;
    bit            e_ack;
    bit            e_done;
    logic [DW-1:0] e_rdata;
    logic [DW-1:0] m_mem [NR];

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_check(input string tag);
        bit            x_stall, x_we;
        logic [AW-1:0] x_a3, x_a2;
        logic [DW-1:0] x_wd;
        if (m_sweep != 0) begin
            x_stall = 1'b1; x_we = 1'b1; x_a3 = AW'(m_sweep); x_wd = 32'h0; x_a2 = core_a2;
        end else if (m_dbg_cycle) begin
            x_stall = 1'b1; x_we = m_lat_we && (m_lat_addr != 5'd0);
            x_a3 = m_lat_addr; x_wd = m_lat_wdata; x_a2 = m_lat_addr;
        end else begin
            x_stall = 1'b0; x_we = core_we; x_a3 = core_waddr; x_wd = core_wdata; x_a2 = core_a2;
        end
        check({tag, ".m_stall"}, 32'(core_stall), 32'(x_stall));
        check({tag, ".m_we3"},   32'(rf_we3), 32'(x_we));
        check({tag, ".m_a2"},    32'(rf_a2), 32'(x_a2));
        if (x_we) begin
            check({tag, ".m_a3"},  32'(rf_a3), 32'(x_a3));
            check({tag, ".m_wd3"}, rf_wd3, x_wd);
        end
        check({tag, ".m_ack"},   32'(dbg_ack), 32'(e_ack));
        check({tag, ".m_done"},  32'(init_done), 32'(e_done));
        check({tag, ".m_rdata"}, dbg_rdata, e_rdata);
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_valid = 1'b1; m_sweep = 1; m_dbg_cycle = 1'b0; m_acking = 1'b0;
            e_ack = 1'b0; e_done = 1'b0; e_rdata = 32'h0;
            for (int k = 0; k < NR; k++) m_mem[k] = 32'hBAD0_BAD0;
        end else if (m_sweep != 0) begin
            m_mem[m_sweep] = 32'h0;
            if (m_sweep == NR - 1) begin
                m_sweep = 0;
                e_done  = 1'b1;
            end else begin
                m_sweep++;
            end
        end else if (m_dbg_cycle) begin
            e_rdata = (m_lat_addr == 5'd0) ? 32'h0 : m_mem[m_lat_addr];
            if (m_lat_we && (m_lat_addr != 5'd0)) m_mem[m_lat_addr] = m_lat_wdata;
            m_dbg_cycle = 1'b0;
            m_acking    = 1'b1;
            e_ack       = 1'b1;
        end else begin
            if (core_we && (core_waddr != 5'd0)) m_mem[core_waddr] = core_wdata;
            if (m_acking) begin
                if (!dbg_req) begin
                    m_acking = 1'b0;
                    e_ack    = 1'b0;
                end
            end else if (dbg_req) begin
                m_lat_we    = dbg_we;
                m_lat_addr  = dbg_addr;
                m_lat_wdata = dbg_wdata;
                m_dbg_cycle = 1'b1;
            end
        end
    endtask

    // msk bits: 0 stall, 1 we3, 2 a3, 3 wd3, 4 a2, 5 ack, 6 rdata, 7 done
    task automatic cycle(input in_t v, input logic [7:0] msk, input exp_t e, input string tag);
        @(negedge clk);
        rst_n = v.rst_n; core_we = v.core_we; core_waddr = v.waddr; core_wdata = v.wdata;
        core_a2 = v.a2; dbg_req = v.req; dbg_we = v.dwe; dbg_addr = v.daddr; dbg_wdata = v.dwdata;
        #1;
        if (m_valid) model_check(tag);
        if (msk[0]) check({tag, ".stall"}, 32'(core_stall), 32'(e.stall));
        if (msk[1]) check({tag, ".we3"},   32'(rf_we3), 32'(e.we3));
        if (msk[2] && e.we3) check({tag, ".a3"}, 32'(rf_a3), 32'(e.a3));
        if (msk[3] && e.we3) check({tag, ".wd3"}, rf_wd3, e.wd3);
        if (msk[4]) check({tag, ".a2"},    32'(rf_a2), 32'(e.a2));
        if (msk[5]) check({tag, ".ack"},   32'(dbg_ack), 32'(e.ack));
        if (msk[6]) check({tag, ".rdata"}, dbg_rdata, e.rdata);
        if (msk[7]) check({tag, ".done"},  32'(init_done), 32'(e.done));
        @(posedge clk);
        model_edge();
    endtask

    function automatic in_t mki(logic rn, logic cwe, logic [AW-1:0] wa, logic [DW-1:0] wd,
                                logic rq, logic dwe, logic [AW-1:0] da, logic [DW-1:0] dwd);
        in_t r;
        r.rst_n = rn; r.core_we = cwe; r.waddr = wa; r.wdata = wd; r.a2 = 5'd17;
        r.req = rq; r.dwe = dwe; r.daddr = da; r.dwdata = dwd;
        return r;
    endfunction

    function automatic exp_t mke(logic st, logic we, logic [AW-1:0] a3, logic [DW-1:0] wd3,
                                 logic [AW-1:0] a2, logic ack, logic [DW-1:0] rd, logic dn);
        exp_t r;
        r.stall = st; r.we3 = we; r.a3 = a3; r.wd3 = wd3; r.a2 = a2; r.ack = ack; r.rdata = rd; r.done = dn;
        return r;
    endfunction

    vec_t tab [27];

    initial begin
        in_t  vin;
        exp_t ex;
        bit            rq, rq_we;
        logic [AW-1:0] rq_addr;
        logic [DW-1:0] rq_wd;

        tab[0]  = '{mki(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'h0),          mke(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd17, 1'b0, 32'h0, 1'b1)};
        tab[1]  = '{mki(1'b1, 1'b1, 5'd3, 32'h33333333, 1'b1, 1'b1, 5'd7, 32'h12345678),   mke(1'b0, 1'b1, 5'd3, 32'h33333333, 5'd17, 1'b0, 32'h0, 1'b1)};
        tab[2]  = '{mki(1'b1, 1'b1, 5'd9, 32'hAAAAAAAA, 1'b1, 1'b1, 5'd7, 32'h12345678),   mke(1'b1, 1'b1, 5'd7, 32'h12345678, 5'd7,  1'b0, 32'h0, 1'b1)};
        tab[3]  = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd7, 32'h12345678),          mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b1, 32'h0, 1'b1)};
        tab[4]  = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd7, 32'h12345678),          mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b1, 32'h0, 1'b1)};
        tab[5]  = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0),                 mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b1, 32'h0, 1'b1)};
        tab[6]  = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd7, 32'h0),                 mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b0, 32'h0, 1'b1)};
        tab[7]  = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd7, 32'h0),                 mke(1'b1, 1'b0, 5'd0, 32'h0, 5'd7,  1'b0, 32'h0, 1'b1)};
        tab[8]  = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0),                 mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b1, 32'h12345678, 1'b1)};
        tab[9]  = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0),                 mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b0, 32'h12345678, 1'b1)};
        tab[10] = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0),                 mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b0, 32'h12345678, 1'b1)};
        tab[11] = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0),                 mke(1'b1, 1'b0, 5'd0, 32'h0, 5'd0,  1'b0, 32'h12345678, 1'b1)};
        tab[12] = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0),                 mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b1, 32'h0, 1'b1)};
        tab[13] = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd0, 32'hFFFFFFFF),          mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b0, 32'h0, 1'b1)};
        tab[14] = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd0, 32'hFFFFFFFF),          mke(1'b1, 1'b0, 5'd0, 32'h0, 5'd0,  1'b0, 32'h0, 1'b1)};
        tab[15] = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0),                 mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b1, 32'h0, 1'b1)};
        tab[16] = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd5, 32'h0),                 mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b0, 32'h0, 1'b1)};
        tab[17] = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd5, 32'h0),                 mke(1'b1, 1'b0, 5'd0, 32'h0, 5'd5,  1'b0, 32'h0, 1'b1)};
        tab[18] = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0),                 mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b1, 32'hDEADBEEF, 1'b1)};
        tab[19] = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd3, 32'h0),                 mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b0, 32'hDEADBEEF, 1'b1)};
        tab[20] = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd3, 32'h0),                 mke(1'b1, 1'b0, 5'd0, 32'h0, 5'd3,  1'b0, 32'hDEADBEEF, 1'b1)};
        tab[21] = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0),                 mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b1, 32'h33333333, 1'b1)};
        tab[22] = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd9, 32'h0),                 mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b0, 32'h33333333, 1'b1)};
        tab[23] = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd9, 32'h0),                 mke(1'b1, 1'b0, 5'd0, 32'h0, 5'd9,  1'b0, 32'h33333333, 1'b1)};
        tab[24] = '{mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd9, 32'h0),                 mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b1, 32'h0, 1'b1)};
        tab[25] = '{mki(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd9, 32'h0),                 mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b1, 32'h0, 1'b1)};
        tab[26] = '{mki(1'b1, 1'b1, 5'd6, 32'h66666666, 1'b0, 1'b0, 5'd0, 32'h0),          mke(1'b1, 1'b1, 5'd1, 32'h0, 5'd17, 1'b0, 32'h0, 1'b0)};

        // Reset, then the full clear sweep
        vin = mki(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        ex  = mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b0, 32'h0, 1'b0);
        cycle(vin, 8'h00, ex, "rst");
        cycle(vin, 8'hE0, ex, "rst_hold");
        for (int i = 1; i < NR; i++) begin
            vin = mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
            ex  = mke(1'b1, 1'b1, AW'(i), 32'h0, 5'd17, 1'b0, 32'h0, 1'b0);
            cycle(vin, 8'hFF, ex, $sformatf("sweep%0d", i));
        end

        for (int r = 0; r < 27; r++) cycle(tab[r].i, 8'hFF, tab[r].e, $sformatf("tab%0d", r));

        // Sweep interrupted by reset at address 10 restarts from address 1
        for (int i = 2; i <= 10; i++) begin
            vin = mki((i == 10) ? 1'b0 : 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
            ex  = mke(1'b1, 1'b1, AW'(i), 32'h0, 5'd17, 1'b0, 32'h0, 1'b0);
            cycle(vin, 8'h87, ex, $sformatf("midsweep%0d", i));
        end
        // Debug request held across the whole sweep: no ack until init completes
        for (int i = 1; i < NR; i++) begin
            vin = mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd4, 32'hCAFEF00D);
            ex  = mke(1'b1, 1'b1, AW'(i), 32'h0, 5'd17, 1'b0, 32'h0, 1'b0);
            cycle(vin, 8'hA7, ex, $sformatf("resweep%0d", i));
        end
        ex = mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b0, 32'h0, 1'b1);
        cycle(vin, 8'hA3, ex, "init_req_idle");
        ex = mke(1'b1, 1'b1, 5'd4, 32'hCAFEF00D, 5'd4, 1'b0, 32'h0, 1'b1);
        cycle(vin, 8'h1F, ex, "init_req_dbg");
        ex = mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b1, 32'h0, 1'b1);
        cycle(vin, 8'h61, ex, "init_req_ack");
        vin = mki(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle(vin, 8'h20, ex, "init_req_drop");
        ex = mke(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 1'b0, 32'h0, 1'b1);
        cycle(vin, 8'h20, ex, "init_req_idle2");

        // Random traffic against the reference model with a protocol-following requester
        rq = 1'b0; rq_we = 1'b0; rq_addr = '0; rq_wd = '0;
        for (int n = 0; n < 4000; n++) begin
            if (!rq) begin
                if ($urandom_range(0, 2) == 0) begin
                    rq = 1'b1; rq_we = 1'($urandom); rq_addr = AW'($urandom); rq_wd = $urandom;
                end
            end else if (e_ack && ($urandom_range(0, 1) == 1)) begin
                rq = 1'b0;
            end
            vin.rst_n  = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            vin.core_we = 1'($urandom);
            vin.waddr  = AW'($urandom);
            vin.wdata  = $urandom;
            vin.a2     = AW'($urandom);
            vin.req    = rq;
            vin.dwe    = rq_we;
            vin.daddr  = rq_addr;
            vin.dwdata = rq_wd;
            cycle(vin, 8'h00, ex, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
